// File: rtl/traj_judge_pkg.sv
// Shared types and constants for the trajectory collision judge.
// Holds the judge FSM state encoding and the deadline result codes.
package traj_judge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StCheck,
        StDone
    } judge_state_e;

    // Deadline result codes; values 1..254 mean "safe up to this step".
    localparam logic [7:0] DL_FAIL = 8'd0;
    localparam logic [7:0] DL_OK   = 8'd255;

endpackage

// File: rtl/traj_obstacle_ram.sv
// Obstacle occupancy map: 2^MapAw words of 32 bits, one bit per grid cell hash.
// Ports:
//   clk_i           - clock
//   we_i / waddr_i / wdata_i - write port (write on clock edge)
//   re_i / raddr_i  - synchronous read request
//   rdata_o         - read data, valid the cycle after re_i
// Contents are deliberately not reset so the map survives a judge reset.
module traj_obstacle_ram #(
    parameter int unsigned MapAw = 11
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [MapAw-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [MapAw-1:0] raddr_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [2**MapAw];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/traj_collision_judge.sv
// Trajectory collision judge.
// Walks N = 2^steps_log2 linearly interpolated points from start_pos to goal_pos,
// hashes each point's grid cell into a bit of the obstacle map and reports the
// first occupied step (or DL_OK when the whole path is clear).
// Ports:
//   CLK, RST_n              - clock, asynchronous active-low reset
//   start                   - request a judgement (sampled only when idle)
//   start_pos, goal_pos     - packed per-axis signed positions, axis i at [POS_W*i +: POS_W]
//   steps_log2              - log2 of the number of interpolation segments
//   map_we/map_addr/map_wdata - obstacle map word write (idle only)
//   busy                    - judgement in progress
//   done                    - one-cycle completion pulse
//   deadline                - 0 fail, 255 clear, otherwise last safe step count
//   map_err                 - one-cycle pulse when a write was dropped while busy
//   judge_cnt, fail_cnt     - saturating statistics, only with TRAJ_JUDGE_STATS_EN defined
module traj_collision_judge
    import traj_judge_pkg::*;
#(
    parameter int STEPPERS_NUM = 6,
    parameter int POS_W        = 32,
    parameter int CELL_SHIFT   = 16,
    parameter int AXIS_BITS    = 8,
    parameter int MAP_AW       = 11
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic                          start,
    input  logic [POS_W*STEPPERS_NUM-1:0] start_pos,
    input  logic [POS_W*STEPPERS_NUM-1:0] goal_pos,
    input  logic [2:0]                    steps_log2,
    input  logic                          map_we,
    input  logic [MAP_AW-1:0]             map_addr,
    input  logic [31:0]                   map_wdata,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    deadline,
    output logic                          map_err
`ifdef TRAJ_JUDGE_STATS_EN
    ,
    output logic [15:0]                   judge_cnt,
    output logic [15:0]                   fail_cnt
`endif
);

    localparam int ACC_W  = POS_W + 8;
    localparam int FLAT_W = STEPPERS_NUM * AXIS_BITS;
    localparam int BA_W   = MAP_AW + 5;

    judge_state_e state_q, state_d;

    logic [7:0] k_q, k_d;
    logic [2:0] s_q, s_d;
    logic [7:0] result_q, result_d;
    logic [4:0] bit_q, bit_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] deadline_q, deadline_d;
    logic       map_err_q, map_err_d;

    logic [STEPPERS_NUM-1:0][POS_W-1:0] origin_q, origin_d;
    logic [STEPPERS_NUM-1:0][POS_W:0]   delta_q, delta_d;
    logic [STEPPERS_NUM-1:0][ACC_W-1:0] acc_q, acc_d;

    logic [STEPPERS_NUM-1:0][ACC_W-1:0] shifted;
    logic [STEPPERS_NUM-1:0][POS_W-1:0] point;
    logic [FLAT_W-1:0]                  flat;
    logic [BA_W-1:0]                    ba;
    logic [7:0]                         n_steps;
    logic [31:0]                        rdata;
    logic                               hit;
    logic                               ram_we;
    logic                               ram_re;

    // Only the cell bits of each point feed the hash.
    logic unused_point;
    assign unused_point = ^{point, shifted};

    assign n_steps = 8'd1 << s_q;

    // Current point and its folded cell hash. Folding bit j onto ba[j % BA_W]
    // is the XOR of consecutive BA_W slices with the top slice zero-padded.
    always_comb begin
        shifted = '0;
        point   = '0;
        flat    = '0;
        ba      = '0;
        for (int i = 0; i < STEPPERS_NUM; i++) begin
            // Arithmetic shift floors toward -inf, so p_N lands exactly on goal.
            shifted[i] = $signed(acc_q[i]) >>> s_q;
            point[i]   = origin_q[i] + shifted[i][POS_W-1:0];
            flat[i*AXIS_BITS +: AXIS_BITS] = point[i][CELL_SHIFT +: AXIS_BITS];
        end
        for (int j = 0; j < FLAT_W; j++) begin
            ba[j % BA_W] = ba[j % BA_W] ^ flat[j];
        end
    end

    assign ram_we = map_we && (state_q == StIdle);
    assign ram_re = (state_q == StAddr);
    assign hit    = rdata[bit_q];

    traj_obstacle_ram #(
        .MapAw (MAP_AW)
    ) u_map (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (map_addr),
        .wdata_i (map_wdata),
        .re_i    (ram_re),
        .raddr_i (ba[BA_W-1:5]),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        s_d        = s_q;
        result_d   = result_q;
        bit_d      = bit_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        deadline_d = deadline_q;
        map_err_d  = map_we && (state_q != StIdle);
        origin_d   = origin_q;
        delta_d    = delta_q;
        acc_d      = acc_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAddr;
                    busy_d  = 1'b1;
                    k_d     = 8'd0;
                    s_d     = steps_log2;
                    for (int i = 0; i < STEPPERS_NUM; i++) begin
                        origin_d[i] = start_pos[POS_W*i +: POS_W];
                        delta_d[i]  = {goal_pos[POS_W*i+POS_W-1], goal_pos[POS_W*i +: POS_W]}
                                    - {start_pos[POS_W*i+POS_W-1], start_pos[POS_W*i +: POS_W]};
                    end
                    acc_d = '0;
                end
            end
            StAddr: begin
                bit_d   = ba[4:0];
                state_d = StCheck;
            end
            StCheck: begin
                if (hit) begin
                    result_d = k_q;
                    state_d  = StDone;
                end else if (k_q == n_steps) begin
                    result_d = DL_OK;
                    state_d  = StDone;
                end else begin
                    k_d = k_q + 8'd1;
                    for (int i = 0; i < STEPPERS_NUM; i++) begin
                        acc_d[i] = acc_q[i] + {{7{delta_q[i][POS_W]}}, delta_q[i]};
                    end
                    state_d = StAddr;
                end
            end
            StDone: begin
                done_d     = 1'b1;
                busy_d     = 1'b0;
                deadline_d = result_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= StIdle;
            k_q        <= '0;
            s_q        <= '0;
            result_q   <= '0;
            bit_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            deadline_q <= DL_FAIL;
            map_err_q  <= 1'b0;
            origin_q   <= '0;
            delta_q    <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            s_q        <= s_d;
            result_q   <= result_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            deadline_q <= deadline_d;
            map_err_q  <= map_err_d;
            origin_q   <= origin_d;
            delta_q    <= delta_d;
            acc_q      <= acc_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign deadline = deadline_q;
    assign map_err  = map_err_q;

`ifdef TRAJ_JUDGE_STATS_EN
    logic [15:0] judge_cnt_q, judge_cnt_d;
    logic [15:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        judge_cnt_d = judge_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        if (state_q == StDone) begin
            if (judge_cnt_q != 16'hFFFF) begin
                judge_cnt_d = judge_cnt_q + 16'd1;
            end
            if ((result_q != DL_OK) && (fail_cnt_q != 16'hFFFF)) begin
                fail_cnt_d = fail_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            judge_cnt_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            judge_cnt_q <= judge_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign judge_cnt = judge_cnt_q;
    assign fail_cnt  = fail_cnt_q;
`else
    // Statistics counters not built.
`endif

endmodule

// File: doc/traj_collision_judge.md
TRAJ_COLLISION_JUDGE -- requirements
Module: traj_collision_judge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- STEPPERS_NUM, 6, axis count.
- POS_W, 32, signed position width per axis.
- CELL_SHIFT, 16, log2 of grid cell width (65536).
- AXIS_BITS, 8, cell bits taken per axis.
- MAP_AW, 11, obstacle map word address width (2048 x 32-bit).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, sole clock.
- RST_n, in, 1, asynchronous active-low reset.
- start, in, 1, request a judgement.
- start_pos, in, POS_W*STEPPERS_NUM, trajectory start; axis i at bits [POS_W*i +: POS_W].
- goal_pos, in, POS_W*STEPPERS_NUM, trajectory goal.
- steps_log2, in, 3, s; N = 2^s interpolation segments.
- map_we, in, 1, obstacle word write.
- map_addr, in, MAP_AW, write address.
- map_wdata, in, 32, occupancy bits.
- busy, out, 1, judgement in progress.
- done, out, 1, one-cycle completion pulse.
- deadline, out, 8, result: 0 = fail, 255 = success, 1..254 = last safe step count (re-plan).
- map_err, out, 1, one-cycle pulse when a write is dropped.

Function
REQ-003 start SHALL be sampled only in IDLE; start while busy SHALL be ignored. start_pos, goal_pos and steps_log2 SHALL be latched at acceptance.
REQ-004 Per axis, delta = goal - start SHALL be computed as a signed (POS_W+1)-bit value. The accumulator acc (POS_W+8 bits, signed) SHALL start at 0 and gain delta per step. The point at step k SHALL be p_k = start + (acc >>> s), using an arithmetic shift that floors toward negative infinity.
REQ-005 Points k = 0..N inclusive SHALL be checked in order; p_N SHALL equal goal_pos exactly.
REQ-006 The cell for axis i SHALL be c_i = p_k[CELL_SHIFT+AXIS_BITS-1 : CELL_SHIFT].
- flat = {c_(STEPPERS_NUM-1), ..., c_0}.
- The bit address ba (MAP_AW+5 bits) SHALL be the XOR of consecutive (MAP_AW+5)-bit slices of flat, with the top slice zero-padded.
- Word = ba[MAP_AW+4:5]; bit = ba[4:0]; a set bit means occupied.
- Aliasing SHALL only produce false collisions, never missed ones.
REQ-007 The state machine SHALL have four states:
- IDLE: on start, go to ADDR with k = 0 and busy = 1.
- ADDR: compute ba and issue a synchronous map read; go to CHECK.
- CHECK: if the bit is set, go to DONE with deadline = k. If the bit is clear and k = N, go to DONE with deadline = 255. Otherwise increment k, update acc, and go to ADDR.
- DONE: assert done for one cycle, clear busy, go to IDLE.
REQ-008 Latency from the accepted start edge to done SHALL be 2*(k_stop+1)+1 cycles. For a clear path this is 2*(N+1)+1.
REQ-009 deadline SHALL hold its value until the next DONE. A collision at k = 0 SHALL yield 0. A collision at k in 1..128 SHALL yield k.
REQ-010 map_we in IDLE SHALL write the map on the same edge. map_we while busy SHALL be dropped and SHALL pulse map_err the next cycle.
REQ-011 start and map_we asserted together in IDLE SHALL both be honoured. The write SHALL complete before the first read, one cycle later.

Reset
REQ-012 RST_n low SHALL asynchronously force IDLE, busy = 0, done = 0, deadline = 0 and map_err = 0, including mid-judgement.
REQ-013 Map contents SHALL NOT be cleared by reset.

Configuration
REQ-014 With TRAJ_JUDGE_STATS_EN defined, outputs judge_cnt[15:0] and fail_cnt[15:0] SHALL exist.
- judge_cnt SHALL increment at each DONE.
- fail_cnt SHALL increment at each DONE with deadline != 255.
- Both SHALL saturate at 0xFFFF and reset to 0.
REQ-015 Without TRAJ_JUDGE_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-016 Package traj_judge_pkg SHALL hold the state enum and the constants DL_FAIL = 8'd0 and DL_OK = 8'd255.
REQ-017 Sub-module traj_obstacle_ram SHALL implement the 2^MAP_AW x 32 map: one write port and a synchronous read port. Address/hash logic SHALL stay in the top.

Verification
REQ-018 Bench scenarios SHALL be (stimulus -> required response):
- Empty map; start 0, goal axis0 = 0x00050000, s = 2 -> deadline 255; done 11 cycles after start.
- Map word 0 = 0x00000001; start and goal at 0 -> deadline 0; done 3 cycles after start.
- Word 0 = 0x00000008; goal axis0 = 0x00080000, s = 3 -> deadline 3; done 9 cycles after start.
- start pulsed while busy -> ignored. map_we while busy -> map_err pulses once; later readback shows the word unchanged.
- RST_n low at the third busy cycle -> busy/deadline/done = 0 immediately. A rerun of the same case matches the undisturbed result.
- Negative delta: start axis0 = 0x00080000, goal 0, obstacle at cell 5 -> deadline 3. Also check floor shift with delta = -1, s = 1 -> p_1 = start - 1.
